// File: rtl/overweight_interlock_pkg.sv
// Shared emergency-path definitions.
// Holds the emergency state encoding and the default timing constants. The door and motor
// emergency arbiters reuse both, so the encoding is fixed at 0..4 and must not be reordered.
package overweight_interlock_pkg;

  typedef enum logic [2:0] {
    EMERG_NORMAL  = 3'd0,
    EMERG_HOLD    = 3'd1,
    EMERG_CLEAR   = 3'd2,
    EMERG_RECHECK = 3'd3,
    EMERG_LOCKOUT = 3'd4
  } emerg_state_e;

  localparam int unsigned HOLD_CYCLES_DEFAULT    = 500;
  localparam int unsigned RECHECK_CYCLES_DEFAULT = 200;
  localparam int unsigned BLANK_CYCLES_DEFAULT   = 2;
  localparam int unsigned BEEP_HALF_DEFAULT      = 25;
  localparam int unsigned MAX_RETRIES_DEFAULT    = 3;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/overweight_interlock_beep_generator.sv
// Beep generator for the overweight alarm.
// While enable is high the beep output toggles every BEEP_HALF cycles; it restarts at 1
// (with a fresh half-period) on every rising edge of enable and is 0 while enable is low.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset
//   enable - beep request; the caller drives it from its next-state so beep lines up
//            with the registered state
//   beep   - registered buzzer pattern
module overweight_interlock_beep_generator #(
  parameter int unsigned BEEP_HALF = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic beep
);

  localparam int unsigned CNT_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEEP_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beep_q, beep_d;
  logic             en_q;

  always_comb begin
    cnt_d  = '0;
    beep_d = 1'b0;
    if (enable && !en_q) begin
      beep_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        beep_d = ~beep_q;
      end else begin
        beep_d = beep_q;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      beep_q <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      beep_q <= beep_d;
      en_q   <= enable;
    end
  end

  assign beep = beep_q;

endmodule

// File: rtl/overweight_interlock.sv
// Overweight interlock: emergency stage downstream of the weight control block.
// On a sticky overweight flag it inhibits motion, holds the doors open and sounds the alarm,
// then periodically pulses reset_weight_flip to re-arm the weight counter and re-checks the
// load. MAX_RETRIES failed re-checks force a maintenance lockout.
// Ports:
//   clk                   - system clock
//   reset                 - synchronous active-high reset
//   weight_limit_exceeded - sticky overweight flag
//   maintenance_clear     - maintenance release, only honoured in lockout
//   reset_weight_flip     - one-cycle weight counter clear pulse
//   motion_inhibit        - blocks the motor controller
//   door_hold_open        - keeps the doors open
//   alarm                 - buzzer drive
//   lockout               - maintenance lockout indicator
//   retry_count           - failed re-checks in the current episode
// BLANK_CYCLES must be below RECHECK_CYCLES and MAX_RETRIES at least 1.
module overweight_interlock
  import overweight_interlock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEFAULT,
  parameter int unsigned RECHECK_CYCLES = RECHECK_CYCLES_DEFAULT,
  parameter int unsigned BLANK_CYCLES   = BLANK_CYCLES_DEFAULT,
  parameter int unsigned BEEP_HALF      = BEEP_HALF_DEFAULT,
  parameter int unsigned MAX_RETRIES    = MAX_RETRIES_DEFAULT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             weight_limit_exceeded,
  input  logic                             maintenance_clear,
  output logic                             reset_weight_flip,
  output logic                             motion_inhibit,
  output logic                             door_hold_open,
  output logic                             alarm,
  output logic                             lockout,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

  localparam logic [2:0] NORMAL  = EMERG_NORMAL;
  localparam logic [2:0] HOLD    = EMERG_HOLD;
  localparam logic [2:0] CLEAR   = EMERG_CLEAR;
  localparam logic [2:0] RECHECK = EMERG_RECHECK;
  localparam logic [2:0] LOCKOUT = EMERG_LOCKOUT;

  localparam int unsigned TIMER_W = $clog2(max_u(HOLD_CYCLES, RECHECK_CYCLES) + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RECHECK_LAST = TIMER_W'(RECHECK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLANK_END    = TIMER_W'(BLANK_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic [2:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [RETRY_W-1:0] retry_inc;
  logic               recheck_hit;
  logic               beep_enable;
  logic               beep;

  // Saturating increment: the counter never wraps even if MAX_RETRIES is hit twice.
  assign retry_inc   = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);
  // The flag is still settling from the clear pulse during the first BLANK_CYCLES.
  assign recheck_hit = weight_limit_exceeded && (timer_q >= BLANK_END);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TIMER_W'(1);
    retry_d = retry_q;
    case (state_q)
      NORMAL: begin
        timer_d = '0;
        if (weight_limit_exceeded) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        // The flag is deliberately ignored here; the full hold period always runs.
        if (timer_q == HOLD_LAST) begin
          state_d = CLEAR;
          timer_d = '0;
        end
      end
      CLEAR: begin
        state_d = RECHECK;
        timer_d = '0;
      end
      RECHECK: begin
        if (recheck_hit) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? LOCKOUT : HOLD;
          timer_d = '0;
        end else if (timer_q == RECHECK_LAST) begin
          state_d = NORMAL;
          retry_d = '0;
          timer_d = '0;
        end
      end
      LOCKOUT: begin
        timer_d = '0;
        retry_d = RETRY_MAX;
        if (maintenance_clear) begin
          state_d = CLEAR;
          retry_d = '0;
        end
      end
      default: begin
        state_d = NORMAL;
        timer_d = '0;
        retry_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  // Driven from next-state so the registered beep is aligned with entry into HOLD.
  assign beep_enable = (state_d == HOLD);

  overweight_interlock_beep_generator #(
    .BEEP_HALF(BEEP_HALF)
  ) u_beep_generator (
    .clk   (clk),
    .reset (reset),
    .enable(beep_enable),
    .beep  (beep)
  );

  assign reset_weight_flip = (state_q == CLEAR);
  assign motion_inhibit    = (state_q != NORMAL);
  assign door_hold_open    = (state_q != NORMAL);
  assign lockout           = (state_q == LOCKOUT);
  assign alarm             = beep | (state_q == LOCKOUT);
  assign retry_count       = retry_q;

endmodule

// File: tb/tb_overweight_interlock.sv
// Directed bench for overweight_interlock with short timing parameters.
// Observed outputs are packed as {flip, inhibit, door, alarm, lockout, retry[1:0]}.
module tb_overweight_interlock;

  logic       clk = 1'b0;
  logic       reset;
  logic       weight_limit_exceeded;
  logic       maintenance_clear;
  logic       reset_weight_flip;
  logic       motion_inhibit;
  logic       door_hold_open;
  logic       alarm;
  logic       lockout;
  logic [1:0] retry_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Expected alarm over the 8 HOLD cycles, cycle i at bit i: 1,1,0,0,1,1,0,0.
  logic [7:0] alarm_pat = 8'b0011_0011;

  overweight_interlock #(
    .HOLD_CYCLES   (8),
    .RECHECK_CYCLES(6),
    .BLANK_CYCLES  (2),
    .BEEP_HALF     (2),
    .MAX_RETRIES   (3)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .weight_limit_exceeded(weight_limit_exceeded),
    .maintenance_clear    (maintenance_clear),
    .reset_weight_flip    (reset_weight_flip),
    .motion_inhibit       (motion_inhibit),
    .door_hold_open       (door_hold_open),
    .alarm                (alarm),
    .lockout              (lockout),
    .retry_count          (retry_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  function automatic logic [6:0] obs();
    return {reset_weight_flip, motion_inhibit, door_hold_open, alarm, lockout, retry_count};
  endfunction

  function automatic logic [6:0] nrm(input logic [1:0] r);
    return {5'b00000, r};
  endfunction
  function automatic logic [6:0] hld(input logic a, input logic [1:0] r);
    return {3'b011, a, 1'b0, r};
  endfunction
  function automatic logic [6:0] clr(input logic [1:0] r);
    return {5'b11100, r};
  endfunction
  function automatic logic [6:0] rck(input logic [1:0] r);
    return {5'b01100, r};
  endfunction
  function automatic logic [6:0] lck();
    return {5'b01111, 2'd3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Current observation is the first HOLD cycle; checks it and the 7 that follow.
  task automatic hold_body(input string tag, input logic [1:0] r);
    check($sformatf("%s_hold0", tag), 32'(obs()), 32'(hld(1'b1, r)));
    for (int i = 1; i < 8; i++) begin
      step();
      check($sformatf("%s_hold%0d", tag, i), 32'(obs()), 32'(hld(alarm_pat[i], r)));
    end
  endtask

  // Walks RECHECK cycles 1..6; the flag is raised so that it is sampled at the end of
  // cycle `hit`. With `leave` set the task returns right after that cycle.
  task automatic recheck(input string tag, input logic [1:0] r, input int hit, input bit leave);
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("%s_rck%0d", tag, c), 32'(obs()), 32'(rck(r)));
      weight_limit_exceeded = (c == hit);
      if (leave && c == hit) break;
    end
  endtask

  // From the first HOLD cycle of an episode with retry r, fail the re-check in cycle 3.
  task automatic fail_episode(input string tag, input logic [1:0] r);
    hold_body(tag, r);
    step();
    check($sformatf("%s_clr", tag), 32'(obs()), 32'(clr(r)));
    recheck(tag, r, 3, 1'b1);
    step();
    weight_limit_exceeded = 1'b0;
  endtask

  task automatic to_lockout(input string tag);
    weight_limit_exceeded = 1'b1;
    step();
    weight_limit_exceeded = 1'b0;
    fail_episode({tag, "_e1"}, 2'd0);
    fail_episode({tag, "_e2"}, 2'd1);
    fail_episode({tag, "_e3"}, 2'd2);
    check({tag, "_lck"}, 32'(obs()), 32'(lck()));
  endtask

  initial begin
    reset                 = 1'b1;
    weight_limit_exceeded = 1'b1;
    maintenance_clear     = 1'b0;

    // Reset dominates an asserted flag.
    step();
    check("rst0", 32'(obs()), 32'(nrm(2'd0)));
    step();
    check("rst1", 32'(obs()), 32'(nrm(2'd0)));

    // Single episode, load clears; maintenance_clear toggled outside LOCKOUT is ignored.
    reset = 1'b0;
    step();
    weight_limit_exceeded = 1'b0;
    maintenance_clear     = 1'b1;
    hold_body("t1", 2'd0);
    step();
    check("t1_clr", 32'(obs()), 32'(clr(2'd0)));
    recheck("t1", 2'd0, 0, 1'b0);
    maintenance_clear = 1'b0;
    step();
    check("t1_nrm", 32'(obs()), 32'(nrm(2'd0)));
    maintenance_clear = 1'b1;
    step();
    check("t1_mc_idle", 32'(obs()), 32'(nrm(2'd0)));
    maintenance_clear = 1'b0;

    // Flag raised in blanked RECHECK cycles 1 and 2 is ignored.
    for (int hit = 1; hit <= 2; hit++) begin
      weight_limit_exceeded = 1'b1;
      step();
      weight_limit_exceeded = 1'b0;
      hold_body($sformatf("t2_%0d", hit), 2'd0);
      step();
      check($sformatf("t2_%0d_clr", hit), 32'(obs()), 32'(clr(2'd0)));
      recheck($sformatf("t2_%0d", hit), 2'd0, hit, 1'b0);
      step();
      check($sformatf("t2_%0d_nrm", hit), 32'(obs()), 32'(nrm(2'd0)));
    end

    // Three failed re-checks escalate to LOCKOUT, which holds without maintenance_clear.
    to_lockout("t3");
    for (int i = 0; i < 50; i++) begin
      weight_limit_exceeded = i[0];
      step();
      check($sformatf("t4_hold%0d", i), 32'(obs()), 32'(lck()));
    end
    weight_limit_exceeded = 1'b0;
    maintenance_clear     = 1'b1;
    step();
    maintenance_clear = 1'b0;
    check("t4_clr", 32'(obs()), 32'(clr(2'd0)));
    recheck("t4", 2'd0, 0, 1'b0);
    step();
    check("t4_nrm", 32'(obs()), 32'(nrm(2'd0)));

    // Reset mid-HOLD, sampled at the end of HOLD cycle 4.
    weight_limit_exceeded = 1'b1;
    step();
    weight_limit_exceeded = 1'b0;
    check("t5_hold0", 32'(obs()), 32'(hld(1'b1, 2'd0)));
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("t5_hold%0d", i), 32'(obs()), 32'(hld(alarm_pat[i], 2'd0)));
    end
    reset = 1'b1;
    step();
    check("t5_rst", 32'(obs()), 32'(nrm(2'd0)));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("t5_idle%0d", i), 32'(obs()), 32'(nrm(2'd0)));
    end

    // Reset mid-LOCKOUT with both inputs asserted.
    to_lockout("t6");
    reset                 = 1'b1;
    weight_limit_exceeded = 1'b1;
    maintenance_clear     = 1'b1;
    step();
    check("t6_rst", 32'(obs()), 32'(nrm(2'd0)));
    reset                 = 1'b0;
    weight_limit_exceeded = 1'b0;
    maintenance_clear     = 1'b0;
    step();
    check("t6_idle", 32'(obs()), 32'(nrm(2'd0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/overweight_interlock.md
Name: overweight_interlock

Overview:
- Emergency-path stage directly downstream of the weight control block.
- Consumes the sticky `weight_limit_exceeded` flag and enforces the overweight response:
  - inhibit car motion,
  - hold the doors open,
  - sound the alarm.
- Periodically issues `reset_weight_flip` to re-arm the weight counter and re-check the load; repeated failures escalate to a maintenance lockout.

Parameters:
- HOLD_CYCLES, 500: cycles spent in HOLD before each clear/re-check attempt.
- RECHECK_CYCLES, 200: length of the re-check window after a clear pulse.
- BLANK_CYCLES, 2: leading cycles of the re-check window in which `weight_limit_exceeded` is ignored (flag settling after clear); must be < RECHECK_CYCLES.
- BEEP_HALF, 25: alarm half-period, in cycles, during HOLD.
- MAX_RETRIES, 3: failed re-checks that force LOCKOUT; must be >= 1.

Ports:
- clk  in  1  system clock; single clock domain, all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- weight_limit_exceeded  in  1  sticky overweight flag from the weight control block.
- maintenance_clear  in  1  maintenance release; acted on only in LOCKOUT.
- reset_weight_flip  out  1  one-cycle pulse that clears the weight counter.
- motion_inhibit  out  1  blocks the motor controller while asserted.
- door_hold_open  out  1  forces the door controller to keep the doors open.
- alarm  out  1  buzzer drive.
- lockout  out  1  maintenance lockout indicator.
- retry_count  out  $clog2(MAX_RETRIES+1)  failed re-checks in the current episode.

Behaviour:
- Reset: at a clock edge with reset=1, the state goes to NORMAL and every output, the timer and retry_count go to 0. Reset overrides all inputs in every state, including mid-HOLD and LOCKOUT.
- All outputs are registered and decoded from the registered state, so a transition taken at edge k is visible from edge k onward.

States:
- NORMAL: all outputs 0.
  - weight_limit_exceeded=1 sampled -> HOLD; timer and beep phase start at 0.
- HOLD: motion_inhibit=1, door_hold_open=1.
  - alarm starts at 1 on entry and toggles every BEEP_HALF cycles.
  - After HOLD_CYCLES cycles in HOLD -> CLEAR.
- CLEAR: exactly one cycle.
  - reset_weight_flip=1, motion_inhibit=1, door_hold_open=1, alarm=0.
  - Always -> RECHECK. weight_limit_exceeded is ignored.
- RECHECK: motion_inhibit=1, door_hold_open=1, alarm=0.
  - The first BLANK_CYCLES cycles ignore weight_limit_exceeded.
  - If weight_limit_exceeded=1 is sampled after blanking, retry_count increments. If the new count equals MAX_RETRIES -> LOCKOUT; otherwise -> HOLD with the timer restarted.
  - If RECHECK_CYCLES cycles elapse with no qualified assertion -> NORMAL and retry_count clears to 0.
- LOCKOUT: motion_inhibit=1, door_hold_open=1, alarm=1 steady, lockout=1.
  - retry_count holds at MAX_RETRIES.
  - maintenance_clear=1 -> CLEAR with retry_count cleared to 0. The recovery path then runs exactly as above.

Boundary conditions:
- maintenance_clear in any state other than LOCKOUT: ignored.
- weight_limit_exceeded dropping to 0 during HOLD: no early exit; the full HOLD period always completes.
- Timer width: $clog2(max(HOLD_CYCLES, RECHECK_CYCLES)+1). The timer never wraps; it is reset on every state change.
- retry_count saturates; it never wraps.

Decomposition:
- Shared emergency package holds:
  - state enum {NORMAL, HOLD, CLEAR, RECHECK, LOCKOUT} with fixed 3-bit encoding 0..4,
  - default timing constants, for reuse by the door/motor emergency arbiters.
- One natural sub-module, `beep_generator`: enable plus BEEP_HALF-period toggle, restarted at 1 on enable rising.
- The FSM, timer and retry counter stay in the top level.

Test Plan (HOLD_CYCLES=8, RECHECK_CYCLES=6, BLANK_CYCLES=2, BEEP_HALF=2, MAX_RETRIES=3):
- Reset held 2 cycles with weight_limit_exceeded=1 -> all outputs 0, state NORMAL; HOLD entered on the first edge after reset drops.
- Exceeded pulse, then the load clears -> HOLD for 8 cycles, alarm pattern 1,1,0,0,1,1,0,0; reset_weight_flip high for exactly 1 cycle; 6 RECHECK cycles; NORMAL with retry_count=0.
- Exceeded re-asserted in RECHECK cycle 1 (blanked), then low -> ignored; returns to NORMAL after 6 cycles.
- Exceeded re-asserted in RECHECK cycle 3, repeated three times -> retry_count goes 1, 2, 3; LOCKOUT on the third; lockout=1, alarm steady 1.
- In LOCKOUT, maintenance_clear held low for 50 cycles -> stays in LOCKOUT. Then maintenance_clear=1 -> CLEAR pulse, retry_count=0, RECHECK, NORMAL.
- reset asserted mid-HOLD (cycle 4) and mid-LOCKOUT -> next edge: NORMAL, all outputs 0, no reset_weight_flip pulse.
